// File: rtl/siren_tone_detector.sv
// Square-wave period meter for siren tones: measures rising-edge spacing,
// detects a steady tone and flags switches between distinct steady tones.
module siren_tone_detector #(
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 1000000,
    parameter int TOL     = 4,
    parameter int HOLD_N  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             speaker_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             tone_active,
    output logic             silent,
    output logic             tone_stable,
    output logic [CNT_W-1:0] locked_period,
    output logic             tone_change,
    output logic [7:0]       change_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [3:0]       HOLD_C    = 4'(HOLD_N);

    // Unsigned distance between two periods without wrap-around.
    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t           state_r;
    logic             s1_r, s2_r, s3_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] prev_r;
    logic [3:0]       match_r;
    logic             pv_first_r;
    logic             lock_valid_r;

    logic             rise_s;
    logic             sat_s;
    logic             enter_idle_s;
    logic [3:0]       match_inc_s;

    assign rise_s       = s2_r & ~s3_r;
    assign sat_s        = (cnt_r == TIMEOUT_C);
    assign enter_idle_s = (state_r != IDLE) & sat_s & ~rise_s;
    assign match_inc_s  = (match_r >= HOLD_C) ? HOLD_C : (match_r + 4'd1);

    // Input synchroniser, edge history and saturating period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r  <= 1'b0;
            s2_r  <= 1'b0;
            s3_r  <= 1'b0;
            cnt_r <= '0;
        end else begin
            s1_r <= speaker_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
            if (rise_s) begin
                cnt_r <= ONE_C;
            end else if (!sat_s) begin
                cnt_r <= cnt_r + ONE_C;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Measurement FSM plus the stability/lock stage that trails each period by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            period        <= '0;
            period_valid  <= 1'b0;
            pv_first_r    <= 1'b0;
            tone_active   <= 1'b0;
            silent        <= 1'b1;
            prev_r        <= '0;
            match_r       <= 4'd0;
            tone_stable   <= 1'b0;
            locked_period <= '0;
            lock_valid_r  <= 1'b0;
            tone_change   <= 1'b0;
            change_count  <= 8'd0;
        end else begin
            period_valid <= 1'b0;
            pv_first_r   <= 1'b0;
            tone_change  <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r <= ARMED;
                        silent  <= 1'b0;
                    end
                end
                ARMED: begin
                    if (rise_s) begin
                        period       <= cnt_r;
                        period_valid <= 1'b1;
                        pv_first_r   <= 1'b1;
                        state_r      <= TRACK;
                        tone_active  <= 1'b1;
                    end else if (sat_s) begin
                        state_r <= IDLE;
                        silent  <= 1'b1;
                    end
                end
                TRACK: begin
                    if (rise_s) begin
                        period       <= cnt_r;
                        period_valid <= 1'b1;
                    end else if (sat_s) begin
                        state_r     <= IDLE;
                        tone_active <= 1'b0;
                        silent      <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    tone_active <= 1'b0;
                    silent      <= 1'b1;
                end
            endcase

            // The first period after arming has no predecessor, so only later ones are compared.
            if (enter_idle_s) begin
                tone_stable  <= 1'b0;
                match_r      <= 4'd0;
                change_count <= 8'd0;
                lock_valid_r <= 1'b0;
            end else if (period_valid && !pv_first_r) begin
                if (abs_diff(period, prev_r) <= TOL_C) begin
                    match_r <= match_inc_s;
                    if ((match_inc_s == HOLD_C) && !tone_stable) begin
                        tone_stable   <= 1'b1;
                        locked_period <= period;
                        lock_valid_r  <= 1'b1;
                        if (lock_valid_r && (abs_diff(period, locked_period) > TOL_C)) begin
                            tone_change <= 1'b1;
                            if (change_count != 8'hFF) begin
                                change_count <= change_count + 8'd1;
                            end
                        end
                    end
                end else begin
                    match_r     <= 4'd0;
                    tone_stable <= 1'b0;
                end
            end

            if (period_valid) begin
                prev_r <= period;
            end
        end
    end

endmodule

// File: tb/tb_siren_tone_detector.sv
// Randomised scoreboard bench: an event-level tone model predicts every
// period report and the stability/lock state that follows it.
module tb_siren_tone_detector;

    localparam int CNT_W   = 20;
    localparam int TIMEOUT = 1000;
    localparam int TOL     = 4;
    localparam int HOLD_N  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             speaker_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             tone_active;
    logic             silent;
    logic             tone_stable;
    logic [CNT_W-1:0] locked_period;
    logic             tone_change;
    logic [7:0]       change_count;

    siren_tone_detector #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TOL(TOL), .HOLD_N(HOLD_N)
    ) dut (
        .clk(clk), .rst(rst), .speaker_in(speaker_in),
        .period(period), .period_valid(period_valid),
        .tone_active(tone_active), .silent(silent),
        .tone_stable(tone_stable), .locked_period(locked_period),
        .tone_change(tone_change), .change_count(change_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int per;
        bit stable;
        int locked;
        bit chg;
        int ccount;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: works on the spacing of rising edges only.
    int m_state;      // 0 silent, 1 waiting for first period, 2 measuring
    int m_last, m_prev, m_match, m_locked, m_cc;
    bit m_stable, m_lvalid;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        m_state = 0; m_last = 0; m_prev = 0; m_match = 0;
        m_locked = 0; m_cc = 0; m_stable = 0; m_lvalid = 0;
    endtask

    task automatic model_rise(input int t);
        int gap;
        bit chg;
        exp_t e;
        gap = t - m_last;
        chg = 1'b0;
        if (m_state != 0 && gap > TIMEOUT) begin
            m_state = 0; m_stable = 0; m_match = 0; m_cc = 0; m_lvalid = 0;
        end
        if (m_state == 0) begin
            m_state = 1;
        end else begin
            if (m_state == 2) begin
                if (iabs(gap - m_prev) <= TOL) begin
                    if (m_match < HOLD_N) m_match++;
                    if (m_match == HOLD_N && !m_stable) begin
                        m_stable = 1;
                        if (m_lvalid && iabs(gap - m_locked) > TOL) begin
                            chg = 1'b1;
                            if (m_cc < 255) m_cc++;
                        end
                        m_locked = gap;
                        m_lvalid = 1;
                    end
                end else begin
                    m_match = 0;
                    m_stable = 0;
                end
            end
            m_state = 2;
            m_prev = gap;
            e.per = gap; e.stable = m_stable; e.locked = m_locked;
            e.chg = chg; e.ccount = m_cc;
            q.push_back(e);
        end
        m_last = t;
    endtask

    // One full cycle of the square wave, rising edge first.
    task automatic tone(input int p);
        int h;
        h = p / 2;
        model_rise(cyc);
        speaker_in = 1'b1;
        repeat (h) @(negedge clk);
        speaker_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_period_valid"}, period_valid, 0);
        chk({tag, "_tone_active"}, tone_active, 0);
        chk({tag, "_silent"}, silent, 1);
        chk({tag, "_tone_stable"}, tone_stable, 0);
        chk({tag, "_locked_period"}, locked_period, 0);
        chk({tag, "_tone_change"}, tone_change, 0);
        chk({tag, "_change_count"}, change_count, 0);
    endtask

    // Monitor: pops one expectation per period report, checks the trailing stage next cycle.
    initial begin
        exp_t pend;
        bit   pend_v;
        bit   act_prev;
        int   last_pv_cyc;
        pend_v = 0; act_prev = 0; last_pv_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend_v = 0;
                act_prev = 0;
            end else begin
                if (pend_v) begin
                    chk("tone_stable", tone_stable, pend.stable);
                    chk("locked_period", locked_period, pend.locked);
                    chk("tone_change", tone_change, pend.chg);
                    chk("change_count", change_count, pend.ccount);
                    pend_v = 0;
                end else begin
                    chk("tone_change_quiet", tone_change, 0);
                end
                if (period_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_period_valid", period_valid, 0);
                    end else begin
                        pend = q.pop_front();
                        pend_v = 1;
                        chk("period", period, pend.per);
                        chk("tone_active_on_pv", tone_active, 1);
                    end
                    last_pv_cyc = cyc;
                end
                if (silent && act_prev) begin
                    chk("silence_delay", cyc - last_pv_cyc, TIMEOUT);
                    chk("silence_tone_active", tone_active, 0);
                    chk("silence_tone_stable", tone_stable, 0);
                    chk("silence_change_count", change_count, 0);
                end
                act_prev = tone_active;
            end
        end
    end

    initial begin
        int p, n, j;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Steady 100-cycle tone.
        repeat (10) tone(100);
        chk("t1_stable", tone_stable, 1);
        chk("t1_locked", locked_period, 100);

        // Two-tone alternation.
        repeat (3) begin
            repeat (10) tone(100);
            repeat (10) tone(150);
        end
        repeat (6) @(negedge clk);
        chk("t2_change_count", change_count, 5);

        // Jitter then a step just beyond tolerance.
        tone(100); tone(103); tone(98); tone(101); tone(100);
        repeat (5) tone(100);
        tone(106); tone(106);

        // Randomised tones with jitter straddling the tolerance.
        repeat (40) begin
            p = $urandom_range(2, 300);
            n = $urandom_range(3, 10);
            repeat (n) begin
                j = p + $urandom_range(0, 6) - 3;
                if (j < 2) j = 2;
                tone(j);
            end
        end

        // Input stops high: silence after the timeout.
        repeat (8) tone(120);
        model_rise(cyc);
        speaker_in = 1'b1;
        repeat (1100) @(negedge clk);
        chk("t4_silent", silent, 1);
        chk("t4_tone_active", tone_active, 0);
        chk("t4_change_count", change_count, 0);
        speaker_in = 1'b0;
        repeat (5) @(negedge clk);
        repeat (8) tone(90);

        // Reset pulse mid-track.
        repeat (6) tone(70);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        repeat (8) tone(80);

        // Boundaries: shortest period, rise exactly at timeout, one past timeout.
        repeat (8) tone(2);
        repeat (5) tone(50);
        tone(TIMEOUT);
        repeat (3) tone(50);
        tone(TIMEOUT + 1);
        repeat (6) tone(60);

        repeat (10) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
